// File: rtl/button_conditioner.sv
// button_conditioner
//
// Front-end conditioning for raw pushbuttons and slide switches. Every lane
// is synchronized into the clk domain. A four-state counter FSM then
// debounces it. The accepted level is presented together with one-cycle
// edge pulses.
//
// Build option:
//   COND_FALL_PULSE_EN - when defined, adds the fe_out port and its
//                        falling-edge pulse registers. deb_out and re_out
//                        behave identically in both builds.
//
// Parameters:
//   CHANNELS         number of independent lanes (>= 1)
//   DEBOUNCE_CYCLES  cycles a synchronized input must hold a new value
//                    before it is accepted (>= 1)
//   SYNC_STAGES      synchronizer depth per lane (>= 2)
//
// Ports:
//   clk          system clock
//   async_reset  asynchronous, active-low reset
//   raw_in       raw asynchronous button/switch levels, active-high
//   deb_out      debounced level per lane
//   re_out       one-cycle pulse on each accepted 0->1 change of deb_out
//   fe_out       one-cycle pulse on each accepted 1->0 change of deb_out
//                (COND_FALL_PULSE_EN builds only)

module button_conditioner #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                clk,
  input  logic                async_reset,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] deb_out,
  output logic [CHANNELS-1:0] re_out
`ifdef COND_FALL_PULSE_EN
  ,
  output logic [CHANNELS-1:0] fe_out
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEB_CNT = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    STABLE_LO,
    CHECK_HI,
    STABLE_HI,
    CHECK_LO
  } lane_state_e;

  // Synchronizer chain. This is a plain shift of raw_in with no logic
  // between stages, so that metastability has whole cycles to settle.
  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_d [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_s;

  always_comb begin
    sync_d[0] = raw_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    lane_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             deb_q, deb_d;
    logic             re_q, re_d;
`ifdef COND_FALL_PULSE_EN
    logic             fe_q, fe_d;
`endif

    // The counter reaches DEBOUNCE_CYCLES only while the input keeps
    // holding its new value. The comparison against DEB_CNT happens before
    // any increment, so the counter can never pass it or wrap. Any
    // disagreement sends the lane back to its stable state with a cleared
    // count. A bounce therefore always costs a complete new interval.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      deb_d   = deb_q;
      re_d    = 1'b0;
`ifdef COND_FALL_PULSE_EN
      fe_d    = 1'b0;
`endif
      case (state_q)
        STABLE_LO: begin
          if (sync_s[g]) begin
            state_d = CHECK_HI;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d   = '0;
          end
        end
        CHECK_HI: begin
          if (!sync_s[g]) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
          end else if (cnt_q == DEB_CNT) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
            deb_d   = 1'b1;
            re_d    = 1'b1;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!sync_s[g]) begin
            state_d = CHECK_LO;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d   = '0;
          end
        end
        CHECK_LO: begin
          if (sync_s[g]) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
          end else if (cnt_q == DEB_CNT) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
            deb_d   = 1'b0;
`ifdef COND_FALL_PULSE_EN
            fe_d    = 1'b1;
`endif
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          deb_d   = 1'b0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge async_reset) begin
      if (!async_reset) begin
        state_q <= STABLE_LO;
        cnt_q   <= '0;
        deb_q   <= 1'b0;
        re_q    <= 1'b0;
`ifdef COND_FALL_PULSE_EN
        fe_q    <= 1'b0;
`endif
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        deb_q   <= deb_d;
        re_q    <= re_d;
`ifdef COND_FALL_PULSE_EN
        fe_q    <= fe_d;
`endif
      end
    end

    assign deb_out[g] = deb_q;
    assign re_out[g]  = re_q;
`ifdef COND_FALL_PULSE_EN
    assign fe_out[g]  = fe_q;
`endif
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner
//
// Self-checking bench for button_conditioner with CHANNELS=4,
// DEBOUNCE_CYCLES=4 and SYNC_STAGES=2. The reference model does not track
// FSM states. It keeps the raw value sampled at each clk edge. A lane
// accepts a new level when the last DEBOUNCE_CYCLES+1 samples that have
// cleared the synchronizer all agree on that level. Directed scenarios also
// check fixed edge counts derived from the latency rule.

module tb_button_conditioner;

  localparam int CHANNELS = 4;
  localparam int DEB      = 4;
  localparam int SYNC     = 2;
  localparam int WL       = SYNC + DEB;

  logic                clk = 1'b0;
  logic                async_reset = 1'b0;
  logic [CHANNELS-1:0] raw_in = '0;
  logic [CHANNELS-1:0] deb_out;
  logic [CHANNELS-1:0] re_out;
`ifdef COND_FALL_PULSE_EN
  logic [CHANNELS-1:0] fe_out;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  button_conditioner #(
    .CHANNELS       (CHANNELS),
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clk        (clk),
    .async_reset(async_reset),
    .raw_in     (raw_in),
    .deb_out    (deb_out),
    .re_out     (re_out)
`ifdef COND_FALL_PULSE_EN
    ,
    .fe_out     (fe_out)
`endif
  );

  always #5 clk = ~clk;

  // Reference model. win[0] holds the sample from the previous edge and
  // win[i] holds the sample from i edges before that. Samples that the
  // FSM can observe at the current edge are win[SYNC-1 .. SYNC+DEB-1].
  logic [CHANNELS-1:0] win [WL];
  logic [CHANNELS-1:0] m_deb, m_re, m_fe;
  logic [CHANNELS-1:0] nx_deb, nx_re, nx_fe;

  always_comb begin
    nx_deb = m_deb;
    nx_re  = '0;
    nx_fe  = '0;
    for (int l = 0; l < CHANNELS; l++) begin
      int ones;
      ones = 0;
      for (int i = SYNC - 1; i < WL; i++) begin
        ones += int'(win[i][l]);
      end
      if (!m_deb[l] && ones == DEB + 1) begin
        nx_deb[l] = 1'b1;
        nx_re[l]  = 1'b1;
      end else if (m_deb[l] && ones == 0) begin
        nx_deb[l] = 1'b0;
        nx_fe[l]  = 1'b1;
      end
    end
  end

  always @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      for (int i = 0; i < WL; i++) win[i] <= '0;
      m_deb <= '0;
      m_re  <= '0;
      m_fe  <= '0;
    end else begin
      win[0] <= raw_in;
      for (int i = 1; i < WL; i++) win[i] <= win[i-1];
      m_deb <= nx_deb;
      m_re  <= nx_re;
      m_fe  <= nx_fe;
    end
  end

  task automatic test_reset();
    raw_in      = '0;
    async_reset = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({deb_out, re_out} !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_hold: deb=%b re=%b expected 0000 0000", deb_out, re_out);
    end
    async_reset = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({deb_out, re_out} !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_release: deb=%b re=%b expected 0000 0000", deb_out, re_out);
    end
  endtask

  task automatic test_single_rise();
    raw_in[0] = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      logic [CHANNELS-1:0] exp_deb, exp_re;
      @(negedge clk);
      exp_deb = (n >= 7) ? 4'b0001 : 4'b0000;
      exp_re  = (n == 7) ? 4'b0001 : 4'b0000;
      tests_run++;
      if (deb_out !== exp_deb || re_out !== exp_re) begin
        tests_failed++;
        $display("[TB] FAIL single_rise edge %0d: deb=%b re=%b expected deb=%b re=%b",
                 n, deb_out, re_out, exp_deb, exp_re);
      end
      tests_run++;
      if (deb_out !== m_deb || re_out !== m_re) begin
        tests_failed++;
        $display("[TB] FAIL single_rise_model edge %0d: deb=%b re=%b expected deb=%b re=%b",
                 n, deb_out, re_out, m_deb, m_re);
      end
    end
  endtask

  task automatic test_bounce();
    raw_in[1] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      tests_run++;
      if (re_out[1] !== 1'b0 || deb_out[1] !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL bounce_early: deb1=%b re1=%b expected 0 0", deb_out[1], re_out[1]);
      end
    end
    raw_in[1] = 1'b0;
    @(negedge clk);
    raw_in[1] = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      tests_run++;
      if (re_out[1] !== (n == 7) || deb_out[1] !== (n >= 7)) begin
        tests_failed++;
        $display("[TB] FAIL bounce edge %0d: deb1=%b re1=%b expected deb1=%b re1=%b",
                 n, deb_out[1], re_out[1], (n >= 7), (n == 7));
      end
      tests_run++;
      if (deb_out !== m_deb || re_out !== m_re) begin
        tests_failed++;
        $display("[TB] FAIL bounce_model edge %0d: deb=%b re=%b expected deb=%b re=%b",
                 n, deb_out, re_out, m_deb, m_re);
      end
    end
  endtask

  task automatic test_short_pulse();
    raw_in[0] = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      tests_run++;
      if (deb_out !== m_deb || re_out !== m_re) begin
        tests_failed++;
        $display("[TB] FAIL lane0_fall_model edge %0d: deb=%b re=%b expected deb=%b re=%b",
                 n, deb_out, re_out, m_deb, m_re);
      end
    end
    raw_in[0] = 1'b1;
    repeat (2) @(negedge clk);
    raw_in[0] = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      tests_run++;
      if (deb_out !== 4'b0010 || re_out !== 4'b0000) begin
        tests_failed++;
        $display("[TB] FAIL short_pulse edge %0d: deb=%b re=%b expected deb=0010 re=0000",
                 n, deb_out, re_out);
      end
    end
  endtask

  task automatic test_simultaneous();
    raw_in = '0;
    repeat (10) @(negedge clk);
    tests_run++;
    if (deb_out !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL simul_precondition: deb=%b expected 0000", deb_out);
    end
    raw_in = 4'b0011;
    for (int n = 1; n <= 10; n++) begin
      logic [CHANNELS-1:0] exp_deb, exp_re;
      @(negedge clk);
      exp_deb = (n >= 7) ? 4'b0011 : 4'b0000;
      exp_re  = (n == 7) ? 4'b0011 : 4'b0000;
      tests_run++;
      if (deb_out !== exp_deb || re_out !== exp_re) begin
        tests_failed++;
        $display("[TB] FAIL simultaneous edge %0d: deb=%b re=%b expected deb=%b re=%b",
                 n, deb_out, re_out, exp_deb, exp_re);
      end
    end
  endtask

  task automatic test_reset_mid();
    // Lanes 0/1 are still showing 1 while lane 2 builds up its count.
    raw_in = 4'b0100;
    repeat (5) @(negedge clk);
    #2 async_reset = 1'b0;
    #1;
    tests_run++;
    if (deb_out !== 4'b0000 || re_out !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_assert: deb=%b re=%b expected 0000 0000", deb_out, re_out);
    end
    @(negedge clk);
    async_reset = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      logic [CHANNELS-1:0] exp_deb, exp_re;
      @(negedge clk);
      exp_deb = (n >= 7) ? 4'b0100 : 4'b0000;
      exp_re  = (n == 7) ? 4'b0100 : 4'b0000;
      tests_run++;
      if (deb_out !== exp_deb || re_out !== exp_re) begin
        tests_failed++;
        $display("[TB] FAIL reset_mid_release edge %0d: deb=%b re=%b expected deb=%b re=%b",
                 n, deb_out, re_out, exp_deb, exp_re);
      end
    end
  endtask

  task automatic test_fall();
    raw_in[0] = 1'b1;
    repeat (10) @(negedge clk);
    tests_run++;
    if (deb_out[0] !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL fall_precondition: deb0=%b expected 1", deb_out[0]);
    end
    raw_in[0] = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      tests_run++;
      if (deb_out[0] !== (n < 7) || re_out[0] !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL fall edge %0d: deb0=%b re0=%b expected deb0=%b re0=0",
                 n, deb_out[0], re_out[0], (n < 7));
      end
`ifdef COND_FALL_PULSE_EN
      tests_run++;
      if (fe_out !== ((n == 7) ? 4'b0001 : 4'b0000)) begin
        tests_failed++;
        $display("[TB] FAIL fall_pulse edge %0d: fe=%b expected %b",
                 n, fe_out, (n == 7) ? 4'b0001 : 4'b0000);
      end
`endif
    end
  endtask

  task automatic test_random();
    int hold [CHANNELS];
    for (int l = 0; l < CHANNELS; l++) hold[l] = $urandom_range(1, 10);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      tests_run++;
      if (deb_out !== m_deb || re_out !== m_re) begin
        tests_failed++;
        $display("[TB] FAIL random cycle %0d: deb=%b re=%b expected deb=%b re=%b",
                 cyc, deb_out, re_out, m_deb, m_re);
      end
`ifdef COND_FALL_PULSE_EN
      tests_run++;
      if (fe_out !== m_fe) begin
        tests_failed++;
        $display("[TB] FAIL random_fe cycle %0d: fe=%b expected %b", cyc, fe_out, m_fe);
      end
`endif
      if (cyc == 1500) begin
        #2 async_reset = 1'b0;
        #1;
        tests_run++;
        if (deb_out !== 4'b0000 || re_out !== 4'b0000) begin
          tests_failed++;
          $display("[TB] FAIL random_reset: deb=%b re=%b expected 0000 0000", deb_out, re_out);
        end
        @(negedge clk);
        async_reset = 1'b1;
      end
      for (int l = 0; l < CHANNELS; l++) begin
        hold[l]--;
        if (hold[l] <= 0) begin
          raw_in[l] = ~raw_in[l];
          hold[l]   = $urandom_range(1, 10);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_rise();
    test_bounce();
    test_short_pulse();
    test_simultaneous();
    test_reset_mid();
    test_fall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end conditioning stage for raw board pushbuttons and slide switches.
- Each channel is synchronized into the clk domain, debounced by a per-channel counter FSM, and edge-detected.
- Outputs: a clean level (x_debounced) and a one-cycle rising-edge pulse (x_re), consumed by the LED shifter / parity display stage downstream.
- CHANNELS independent, identical lanes; no cross-channel interaction.

Parameters:
- CHANNELS, 4, number of independent input lanes (>=1).
- DEBOUNCE_CYCLES, 500000, consecutive clk cycles a synchronized input must hold a new value before it is accepted (10 ms at 50 MHz); legal range >=1.
- SYNC_STAGES, 2, synchronizer flip-flop depth per lane; legal range >=2.

Ports:
- clk  input  1  system clock.
- async_reset  input  1  asynchronous, active-low reset.
- raw_in  input  CHANNELS  raw, asynchronous button/switch levels, active-high.
- deb_out  output  CHANNELS  debounced level per lane.
- re_out  output  CHANNELS  one-cycle pulse on each accepted 0->1 transition of deb_out.
- fe_out  output  CHANNELS  one-cycle pulse on each accepted 1->0 transition; present only with COND_FALL_PULSE_EN.

Behaviour:
- Reset (async_reset=0, asynchronous assert, synchronous-safe release):
  - all synchronizer FFs = 0, deb_out = 0, re_out = 0, fe_out = 0;
  - every lane FSM = STABLE_LO, counters = 0.
- Synchronizer: raw_in passes through SYNC_STAGES FFs; s = last stage. No logic between stages.
- Per-lane FSM (states STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO):
  - STABLE_LO: s=1 -> CHECK_HI, cnt<=1; else stay, cnt<=0.
  - CHECK_HI: s=0 -> STABLE_LO, cnt<=0 (glitch rejected). s=1 and cnt==DEBOUNCE_CYCLES -> STABLE_HI, deb_out<=1, re_out<=1. Otherwise cnt<=cnt+1.
  - STABLE_HI / CHECK_LO: mirror of the two states above with polarity inverted; acceptance sets deb_out<=0 and fe_out<=1 (if enabled).
- Counter:
  - width $clog2(DEBOUNCE_CYCLES+1);
  - never exceeds DEBOUNCE_CYCLES; no wrap.
  - With DEBOUNCE_CYCLES=1, acceptance occurs on the cycle after entering CHECK_*.
- Latency: a clean raw step to a stable value reaches deb_out exactly SYNC_STAGES + DEBOUNCE_CYCLES + 1 rising clk edges after the first edge that samples the new raw value.
- Pulses:
  - re_out and fe_out are registered.
  - Each is high for exactly one cycle, the same cycle deb_out first shows the new value.
  - Pulses are never asserted in consecutive cycles on the same lane.
- Any bounce during CHECK_* restarts from the stable state; the full DEBOUNCE_CYCLES is required after the last bounce.
- Simultaneous events on different lanes are fully independent; multiple re_out bits may assert in the same cycle.
- Reset mid-debounce aborts the count. No pulse is emitted on reset assert or release.
- An input held at 1 through reset release produces re_out after the normal latency. This is intended.

Optional Feature:
- Macro COND_FALL_PULSE_EN.
- Defined: fe_out port exists and pulses as described above.
- Undefined: fe_out port and its registers are absent. deb_out and re_out behaviour is identical in both builds.

Test Plan:
- DEBOUNCE_CYCLES=4, SYNC_STAGES=2, raw_in[0] 0->1 held -> deb_out[0]=1 and re_out[0]=1 on the 7th edge after sampling; re_out low on the next cycle; other lanes stay 0.
- raw_in[1] high for 3 cycles, low 1 cycle, then high held -> no pulse during the bounce; re_out[1] fires 7 edges after the final rise.
- raw_in[0] high pulse shorter than 4 cycles (2 cycles) -> deb_out[0] and re_out[0] remain 0 throughout.
- raw_in=4'b0011 rising in the same cycle -> re_out=4'b0011 in the same single cycle; deb_out=4'b0011.
- async_reset driven low while lane 2 is in CHECK_HI with cnt=3 -> all outputs are 0 immediately. After release with raw_in[2] still high, re_out[2] fires after the full latency, not earlier.
- COND_FALL_PULSE_EN defined: lane 0 at deb=1, raw_in[0]->0 held -> deb_out[0]=0 and fe_out[0]=1 for one cycle 7 edges later; re_out[0] stays 0.
